// File: rtl/ser_multi_if.sv
//==============================================================================
// ser_multi_if - handshake and serial-output bundle for ser_multi (rev 1.0)
//==============================================================================
`default_nettype none

interface ser_multi_if #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 3
);
  logic                      enable_i;
  logic [CHANNELS*WIDTH-1:0] d_i;
  logic                      valid_i;
  logic                      ready_o;
  logic [CHANNELS-1:0]       ser_o;
  logic                      word_o;
  logic                      underflow_o;

  modport master (
    output enable_i, d_i, valid_i,
    input  ready_o, ser_o, word_o, underflow_o
  );

  modport slave (
    input  enable_i, d_i, valid_i,
    output ready_o, ser_o, word_o, underflow_o
  );
endinterface

`default_nettype wire

// File: rtl/ser_multi.sv
//==============================================================================
// ser_multi - lockstep multi-lane parallel-to-serial converter with idle fill (rev 1.0)
//==============================================================================
`default_nettype none

module ser_multi #(
  parameter int unsigned      WIDTH     = 10,
  parameter int unsigned      CHANNELS  = 3,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b1101010100)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  ser_multi_if.slave  bus
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0]                cnt;
  logic                            load_slot;
  logic                            full;
  logic [CHANNELS*WIDTH-1:0]       hold;
  logic [CHANNELS-1:0][WIDTH-1:0]  sreg;
  logic [CHANNELS-1:0][WIDTH-1:0]  sreg_shift;
  logic [CHANNELS-1:0]             ser;
  logic                            word_q;
  logic                            underflow_q;

  assign load_slot       = bus.enable_i && (cnt == CNT_LAST);
  assign bus.ready_o     = !full;
  assign bus.ser_o       = ser;
  assign bus.word_o      = word_q;
  assign bus.underflow_o = underflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (bus.enable_i) begin
      cnt <= load_slot ? '0 : cnt + CNT_W'(1);
    end
  end

  // Drain takes priority; ready is low while full, so no accept can collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full <= 1'b0;
      hold <= '0;
    end else if (load_slot && full) begin
      full <= 1'b0;
    end else if (bus.valid_i && !full) begin
      full <= 1'b1;
      hold <= bus.d_i;
    end
  end

  // Pulses follow the load decision; a frozen cycle has no load slot, so they drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      word_q      <= load_slot;
      underflow_q <= load_slot && !full;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg <= '0;
    end else if (load_slot) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        sreg[k] <= full ? hold[k*WIDTH +: WIDTH] : IDLE_WORD;
      end
    end else if (bus.enable_i) begin
      sreg <= sreg_shift;
    end
  end

  generate
    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_lane
      if (LSB_FIRST) begin : g_lsb
        assign sreg_shift[k] = {1'b0, sreg[k][WIDTH-1:1]};
        assign ser[k]        = sreg[k][0];
      end else begin : g_msb
        assign sreg_shift[k] = {sreg[k][WIDTH-2:0], 1'b0};
        assign ser[k]        = sreg[k][WIDTH-1];
      end
    end
  endgenerate

endmodule

`default_nettype wire
